// File: rtl/kbd_tx_fifo.sv
// Byte FIFO between the PS/2 keyboard decoder and the UART transmitter.
// A small FSM launches one byte per UART frame and watches tx_busy for a handshake timeout.
module kbd_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_busy,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          timeout,
    input  logic          clr_flags
);

    localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);
    localparam logic [TW-1:0] ONE_TMR  = TW'(1);
    localparam logic [TW-1:0] TMR_MAX  = TW'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;

    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a push at full is still accepted then.
    assign pop   = (state == IDLE) && !empty && !tx_busy;
    assign push  = in_valid && (!full || pop);
    assign drop  = in_valid && full && !pop;

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            timer    <= '0;
            state    <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase

            // Set events are assigned after the clear so they win on a collision.
            if (clr_flags) begin
                overflow <= 1'b0;
                timeout  <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            tx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_valid <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_MAX) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + ONE_TMR;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/kbd_tx_fifo.md
Name: kbd_tx_fifo

Overview:
- Buffers ASCII bytes from the PS/2 keyboard decoder before the UART transmitter, which sends keyboard data to the CPU.
- The keyboard decoder emits single-cycle valid strobes and has no backpressure. The UART is busy for about 10 bit-times per byte, so fast typing or repeated make codes would otherwise drop bytes.
- Sits between the keyboard decoder output (data/valid) and the UART TX input (data/valid/busy), all in the 24 MHz pixel clock domain.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of two, minimum 2.
- AW, 4: pointer width, equal to log2(DEPTH).
- BUSY_TIMEOUT, 255: maximum cycles to wait for tx_busy to rise after a launch strobe.

Ports:
- clk  in  1  system clock (24 MHz)
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  ASCII byte from the keyboard decoder
- in_valid  in  1  one-cycle strobe qualifying in_data
- tx_data  out  8  byte presented to the UART TX
- tx_valid  out  1  one-cycle launch strobe to the UART TX
- tx_busy  in  1  UART TX busy; high while a byte is shifting out
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- timeout  out  1  sticky: tx_busy never rose within BUSY_TIMEOUT cycles
- clr_flags  in  1  synchronous clear of overflow and timeout

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - Reset values: wr_ptr=0, rd_ptr=0, count=0, tx_data=8'h00, tx_valid=0, overflow=0, timeout=0, state=IDLE, timer=0.
  - Reset mid-transfer discards all stored bytes; no tx_valid is issued after reset deasserts until a new byte is pushed.
- Storage: DEPTH x 8 register array.
  - Pointers are AW bits and wrap modulo DEPTH.
  - count is tracked explicitly; full is count==DEPTH, empty is count==0.
- Push: in_valid=1 and (not full, or a pop in the same cycle) writes mem[wr_ptr] and increments wr_ptr.
  - in_valid=1 while full with no pop: byte dropped, overflow set, pointers unchanged.
- Pop: happens only in the IDLE->LAUNCH transition.
  - tx_data <= mem[rd_ptr], rd_ptr increments, count decrements.
  - Push and pop in the same cycle leave count unchanged.
  - Push into an empty FIFO is visible to the FSM on the next cycle; there is no bypass.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if count!=0 and tx_busy==0, pop and go to LAUNCH.
  - LAUNCH: tx_valid=1 for exactly this one cycle; clear timer; go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy==1, go to WAIT_DONE. Otherwise increment timer. When timer==BUSY_TIMEOUT, set timeout and go to IDLE; the byte counts as sent and is not retried.
  - WAIT_DONE: when tx_busy==0, go to IDLE.
- Latency and throughput:
  - Byte pushed into an empty FIFO with tx_busy low: tx_valid rises 2 cycles after the in_valid cycle.
  - Minimum spacing between consecutive tx_valid strobes is 4 cycles, plus the UART busy time.
- tx_data holds its value from LAUNCH until the next pop; it is stable throughout the busy period.
- Flags:
  - clr_flags clears overflow and timeout.
  - A set event in the same cycle as clr_flags wins; the flag stays 1.
- tx_busy high at IDLE: FSM waits; FIFO continues accepting pushes.

Test Plan:
- Single byte: reset, then in_valid with in_data=8'h41 at cycle 0, tx_busy=0 -> tx_valid high at cycle 2 with tx_data=8'h41. Bench raises tx_busy at cycle 4 for 100 cycles -> count returns to 0 and there is no second strobe.
- Burst: push 8'h30..8'h3F (16 bytes) on consecutive cycles while tx_busy is held high -> count=16, overflow=0, no tx_valid. Release tx_busy and model the UART -> 16 strobes emitted in order 8'h30..8'h3F.
- Overflow: fill to 16 with tx_busy high, push 8'hAA -> overflow=1, count=16, 8'hAA never appears on tx_data. clr_flags -> overflow=0.
- Simultaneous push/pop at full: count=16 and the FSM popping in the same cycle as a push of 8'h55 -> count stays 16, overflow=0, and 8'h55 is transmitted last.
- Timeout: push 8'h42, bench never asserts tx_busy -> timeout=1 exactly BUSY_TIMEOUT+2 cycles after tx_valid. FSM returns to IDLE and the next byte launches normally.
- Async reset: assert reset during WAIT_DONE with count=5 -> outputs immediately at reset values. After release with no pushes, tx_valid stays 0 for 1000 cycles.
